// File: rtl/obi_pkg.sv
// OBI field widths, master identifiers and the address-phase bundle shared by
// the 2:1 arbiter and its response-tracking FIFO.
package obi_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   localparam logic MST1 = 1'b0;
   localparam logic MST2 = 1'b1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wdata;
   } obi_req_t;

endpackage

// File: rtl/obi_resp_fifo.sv
// Small ring-buffer FIFO that remembers which master owns each outstanding read,
// so responses can be steered back in issue order.
module obi_resp_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 1,
   parameter int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push,
   input  logic [WIDTH-1:0] data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == (PTR_W + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Storage carries no reset: entries are only observed while count says they are valid.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr] <= data;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/obi_arbiter_2_to_1.sv
// Round-robin 2:1 OBI arbiter: locks the selection across slave wait states and
// routes read responses back to their issuing master via an owner FIFO.
module obi_arbiter_2_to_1
   import obi_pkg::*;
#(
   parameter int unsigned  RESP_DEPTH = 2,
   localparam int unsigned PTR_W      = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              m1_req_i,
   output logic              m1_gnt_o,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic              m1_we_i,
   input  logic [BE_W-1:0]   m1_be_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_rvalid_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   input  logic              m2_req_i,
   output logic              m2_gnt_o,
   input  logic [ADDR_W-1:0] m2_addr_i,
   input  logic              m2_we_i,
   input  logic [BE_W-1:0]   m2_be_i,
   input  logic [DATA_W-1:0] m2_wdata_i,
   output logic              m2_rvalid_o,
   output logic [DATA_W-1:0] m2_rdata_o,
   output logic              port_req_o,
   input  logic              port_gnt_i,
   output logic [ADDR_W-1:0] port_addr_o,
   output logic              port_we_o,
   output logic [BE_W-1:0]   port_be_o,
   output logic [DATA_W-1:0] port_wdata_o,
   input  logic              port_rvalid_i,
   input  logic [DATA_W-1:0] port_rdata_i,
   output logic              spurious_rvalid_o
);

   logic     rr_last;
   logic     locked;
   logic     lock_sel;
   logic     sel;
   logic     sel_req;
   logic     stall;
   logic     hs;
   logic     fifo_full;
   logic     fifo_empty;
   logic     fifo_head;
   obi_req_t m1_q;
   obi_req_t m2_q;
   obi_req_t sel_q;

   assign m1_q = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};
   assign m2_q = '{addr: m2_addr_i, we: m2_we_i, be: m2_be_i, wdata: m2_wdata_i};

   always_comb begin
      sel = rr_last;
      if (locked) begin
         sel = lock_sel;
      end else if (m1_req_i && !m2_req_i) begin
         sel = MST1;
      end else if (m2_req_i && !m1_req_i) begin
         sel = MST2;
      end else if (m1_req_i && m2_req_i) begin
         sel = ~rr_last;
      end
   end

   assign sel_q   = (sel == MST1) ? m1_q : m2_q;
   assign sel_req = (sel == MST1) ? m1_req_i : m2_req_i;

   // Stall looks only at the registered fullness, keeping rvalid off the grant path.
   assign stall      = fifo_full & ~sel_q.we;
   assign port_req_o = sel_req & ~stall;
   assign hs         = port_req_o & port_gnt_i;

   assign port_addr_o  = sel_q.addr;
   assign port_we_o    = sel_q.we;
   assign port_be_o    = sel_q.be;
   assign port_wdata_o = sel_q.wdata;

   assign m1_gnt_o = hs & (sel == MST1);
   assign m2_gnt_o = hs & (sel == MST2);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_last  <= MST2;
         locked   <= 1'b0;
         lock_sel <= MST1;
      end else if (hs) begin
         rr_last <= sel;
         locked  <= 1'b0;
      end else if (port_req_o) begin
         locked   <= 1'b1;
         lock_sel <= sel;
      end
   end

   obi_resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .WIDTH (1),
      .PTR_W (PTR_W)
   ) u_resp_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (hs & ~sel_q.we),
      .data   (sel),
      .pop    (port_rvalid_i & ~fifo_empty),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .head   (fifo_head)
   );

   assign m1_rvalid_o       = port_rvalid_i & ~fifo_empty & (fifo_head == MST1);
   assign m2_rvalid_o       = port_rvalid_i & ~fifo_empty & (fifo_head == MST2);
   assign m1_rdata_o        = port_rdata_i;
   assign m2_rdata_o        = port_rdata_i;
   assign spurious_rvalid_o = port_rvalid_i & fifo_empty;

endmodule

// File: doc/obi_arbiter_2_to_1.md
Name: obi_arbiter_2_to_1

Overview:
- Shares one OBI slave port between two OBI masters, e.g. two cores or a core plus DMA feeding one memory or peripheral demux.
- Round-robin arbitration in the address phase.
- Holds the selection stable while a request is pending at the slave.
- Tracks owners of outstanding reads in a small FIFO so rvalid/rdata return to the correct master; pipelined reads are supported up to RESP_DEPTH.

Parameters:
- RESP_DEPTH, 2: max outstanding reads; power of 2, ≥1.
- PTR_W, $clog2(RESP_DEPTH) (min 1): FIFO pointer width; derived, not overridden.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- m1_req_i  in  1  master 1 request
- m1_gnt_o  out  1  master 1 grant
- m1_addr_i  in  32  address
- m1_we_i  in  1  write enable
- m1_be_i  in  4  byte enables
- m1_wdata_i  in  32  write data
- m1_rvalid_o  out  1  read response valid
- m1_rdata_o  out  32  read data
- m2_*: same eight ports as m1_*, for master 2
- port_req_o  out  1  slave request
- port_gnt_i  in  1  slave grant
- port_addr_o  out  32  selected address
- port_we_o  out  1  selected write enable
- port_be_o  out  4  selected byte enables
- port_wdata_o  out  32  selected write data
- port_rvalid_i  in  1  slave response valid
- port_rdata_i  in  32  slave read data
- spurious_rvalid_o  out  1  pulse: rvalid with no outstanding read

Behaviour:
- State registers, all asynchronously cleared:
  - rr_last: last-granted master; reset = 2, so master 1 wins the first tie.
  - locked, lock_sel: reset = 0, 1.
  - FIFO rd/wr pointers and count: reset = 0.
- Selection (combinational):
  - If locked: sel = lock_sel.
  - Else if exactly one of m1/m2 requests: sel = that master.
  - Else if both request: sel = the master ≠ rr_last.
  - Else: sel = rr_last, with port_req_o = 0.
- Full-FIFO blocking:
  - stall = FIFO full AND the selected request is a read (we = 0).
  - When stalled: port_req_o = 0 and both gnt = 0.
  - Writes bypass the stall.
- port_req_o = selected m*_req_i AND NOT stall.
- port_addr/we/be/wdata_o are muxed from the selected master.
- Grants:
  - m<sel>_gnt_o = port_gnt_i AND port_req_o.
  - The other master's gnt = 0.
  - Grant is combinational, zero added latency.
- Handshake hs = port_req_o AND port_gnt_i. On hs:
  - rr_last <= sel
  - locked <= 0
- Lock:
  - If port_req_o = 1 AND port_gnt_i = 0: locked <= 1, lock_sel <= sel.
  - This guarantees address stability to the slave across wait cycles.
  - Lock persists until hs; masters must hold req until gnt (OBI rule).
- Read push: hs AND NOT selected we pushes sel (1 bit) into the FIFO.
- Writes: not tracked; no rvalid is expected or returned.
- Response routing:
  - m1_rvalid_o = port_rvalid_i AND FIFO not empty AND head = 1; m2 likewise with head = 2.
  - Both m*_rdata_o = port_rdata_i (broadcast; consumers qualify with rvalid).
  - port_rvalid_i with FIFO not empty pops the head.
- Spurious rvalid:
  - port_rvalid_i with FIFO empty: spurious_rvalid_o = 1 the same cycle (combinational).
  - Dropped: no master sees rvalid, no state change.
- Simultaneous push and pop:
  - Allowed when not full; count unchanged, both pointers advance.
  - When full, a read is stalled even if a pop occurs the same cycle, so there is no comb path from rvalid to gnt.
- Pointer wrap: modulo RESP_DEPTH.
- Reset mid-operation: all tracking is lost; a later slave rvalid for a pre-reset read is flagged spurious.
- Outputs during reset are combinational functions of inputs with reset-state registers.

Decomposition:
- obi_pkg: OBI field widths (ADDR_W=32, DATA_W=32, BE_W=4), master ID localparams MST1=1'b0, MST2=1'b1.
- Sub-module obi_resp_fifo:
  - Parameterized DEPTH / data width 1.
  - push, pop, full, empty, head outputs.
  - Async active-low reset.
  - Reused later by the demux when pipelined reads are added.

Test Plan:
- Single master: m1 read addr 0x1000, gnt same cycle, slave rvalid 2 cycles later with rdata 0xCAFE0001 → m1_rvalid_o = 1 with 0xCAFE0001, m2_rvalid_o = 0.
- Contention: both masters request reads every cycle from reset, slave always grants → grants alternate m1, m2, m1, m2; responses return in the same order to the matching master.
- Wait-state lock: m1 requests, port_gnt_i = 0 for 3 cycles while m2 also requests → port_addr_o stays at m1's address all 3 cycles; m1 granted on cycle 4, m2 granted next.
- Full stall with RESP_DEPTH = 2: two reads outstanding, third read → port_req_o = 0, gnt = 0. A write issued then is granted. After one rvalid, the read is granted the next cycle.
- Spurious and reset: rvalid with FIFO empty → spurious_rvalid_o = 1, no m*_rvalid_o. Assert rst_ni low mid-transaction with 1 read outstanding → FIFO empty immediately (async), and the subsequent rvalid is flagged spurious.
